demux_1a4: RTL and testbench

DEMUX_1A4 -- requirements
Module: demux_1a4

---
 rtl/demux_pkg.sv | 23 ++
 rtl/demux_slot_cnt.sv | 32 +++
 rtl/demux_1a4.sv | 150 +++++++++++++++
 tb/tb_demux_1a4.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg -- shared types and constants for the 1-to-4 lane demultiplexer.
// Optional statistics counter is enabled by defining DEMUX_STATS_EN.
package demux_pkg;

    // Alignment state: waiting for the first valid word, or running through slots
    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } state_e;

    localparam int LANES     = 4;
    localparam int SLOT_W    = 2;
    localparam int WIDTH_DEF = 8;

    // Slot index at which a complete group is handed to the lane outputs
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LANES - 1);

    // Saturating 8-bit increment used by the group statistics counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/demux_slot_cnt.sv
// demux_slot_cnt -- 2-bit slot counter with enable and synchronous clear.
// last_slot_o flags the slot on which a group is complete.
module demux_slot_cnt
    import demux_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              clr_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              last_slot_o
);

    logic [SLOT_W-1:0] slot_q;

    // Slot register: clear has priority, otherwise advance modulo 4 when enabled
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_q <= {SLOT_W{1'b0}};
        end else if (clr_i) begin
            slot_q <= {SLOT_W{1'b0}};
        end else if (en_i) begin
            slot_q <= slot_q + {{(SLOT_W-1){1'b0}}, 1'b1};
        end else begin
            slot_q <= slot_q;
        end
    end

    assign slot_o      = slot_q;
    assign last_slot_o = (slot_q == LAST_SLOT);

endmodule

// File: rtl/demux_1a4.sv
// demux_1a4 -- serial-to-4-lane demultiplexer with group alignment.
// The first valid word after reset (or after a fully invalid group) becomes
// slot 0; every fourth slot the staged group is presented on all lanes at once.
// Define DEMUX_STATS_EN to add the saturating group_cnt output.
module demux_1a4 #(
    parameter int WIDTH = demux_pkg::WIDTH_DEF,
    parameter int LANES = 4
) (
    input  logic             clk_4f,
    input  logic             reset_L,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic [WIDTH-1:0] data_out3,
    output logic             valid_out0,
    output logic             valid_out1,
    output logic             valid_out2,
    output logic             valid_out3,
    output logic             group_strobe
`ifdef DEMUX_STATS_EN
   ,output logic [7:0]       group_cnt
`endif
);

    import demux_pkg::*;

    // The lane ports are fixed at four; any other lane count is rejected
    if (LANES != 4) begin : g_lanes_check
        $error("demux_1a4 supports LANES == 4 only");
    end

    state_e             state_q;
    logic [WIDTH-1:0]   stage_data_q [0:LANES-2];
    logic [LANES-2:0]   stage_vld_q;
    logic [WIDTH-1:0]   dout_q [0:LANES-1];
    logic [LANES-1:0]   vout_q;
    logic               strobe_q;

    logic [SLOT_W-1:0]  slot_s;
    logic               last_slot_s;
    logic               cnt_en_s;
    logic               cnt_clr_s;
    logic               any_valid_s;
    logic               transfer_s;
    logic [WIDTH-1:0]   word_s;

    // Invalid words are zeroed on entry so no lane ever carries stale data
    assign word_s      = valid_in ? data_in : {WIDTH{1'b0}};
    assign any_valid_s = (|stage_vld_q) | valid_in;
    assign transfer_s  = (state_q == RUN) && last_slot_s;

    // Counter runs every cycle in RUN; in WAIT_SYNC only the sync word advances it
    assign cnt_en_s  = (state_q == RUN) | valid_in;
    assign cnt_clr_s = (state_q == WAIT_SYNC) & ~valid_in;

    demux_slot_cnt u_slot_cnt (
        .clk_i       (clk_4f),
        .rst_n_i     (reset_L),
        .en_i        (cnt_en_s),
        .clr_i       (cnt_clr_s),
        .slot_o      (slot_s),
        .last_slot_o (last_slot_s)
    );

    // Alignment FSM with staging registers and registered lane outputs
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= WAIT_SYNC;
            stage_vld_q <= {(LANES-1){1'b0}};
            vout_q      <= {LANES{1'b0}};
            strobe_q    <= 1'b0;
            for (int k = 0; k < LANES - 1; k++) begin
                stage_data_q[k] <= {WIDTH{1'b0}};
            end
            for (int k = 0; k < LANES; k++) begin
                dout_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                WAIT_SYNC: begin
                    if (valid_in) begin
                        stage_data_q[0] <= word_s;
                        stage_vld_q[0]  <= 1'b1;
                        state_q         <= RUN;
                    end else begin
                        state_q <= WAIT_SYNC;
                    end
                end
                RUN: begin
                    if (last_slot_s) begin
                        // Slot 3 completes the group: publish all lanes together
                        for (int k = 0; k < LANES - 1; k++) begin
                            dout_q[k]       <= stage_data_q[k];
                            vout_q[k]       <= stage_vld_q[k];
                            stage_data_q[k] <= {WIDTH{1'b0}};
                        end
                        dout_q[LANES-1] <= word_s;
                        vout_q[LANES-1] <= valid_in;
                        stage_vld_q     <= {(LANES-1){1'b0}};
                        strobe_q        <= 1'b1;
                        // A fully empty group means alignment may be lost
                        state_q         <= any_valid_s ? RUN : WAIT_SYNC;
                    end else begin
                        for (int k = 0; k < LANES - 1; k++) begin
                            if (slot_s == SLOT_W'(k)) begin
                                stage_data_q[k] <= word_s;
                                stage_vld_q[k]  <= valid_in;
                            end
                        end
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= WAIT_SYNC;
                end
            endcase
        end
    end

    assign data_out0    = dout_q[0];
    assign data_out1    = dout_q[1];
    assign data_out2    = dout_q[2];
    assign data_out3    = dout_q[3];
    assign valid_out0   = vout_q[0];
    assign valid_out1   = vout_q[1];
    assign valid_out2   = vout_q[2];
    assign valid_out3   = vout_q[3];
    assign group_strobe = strobe_q;

`ifdef DEMUX_STATS_EN
    logic [7:0] group_cnt_q;

    // Count published groups carrying at least one valid lane, saturating at 255
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            group_cnt_q <= 8'd0;
        end else if (transfer_s && any_valid_s) begin
            group_cnt_q <= sat_inc8(group_cnt_q);
        end else begin
            group_cnt_q <= group_cnt_q;
        end
    end

    assign group_cnt = group_cnt_q;
`endif

endmodule

// File: tb/tb_demux_1a4.sv
// tb_demux_1a4 -- directed self-checking bench for demux_1a4.
module tb_demux_1a4;

    localparam int W = 8;

    logic         clk_4f;
    logic         reset_L;
    logic         valid_in;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out0, data_out1, data_out2, data_out3;
    logic         valid_out0, valid_out1, valid_out2, valid_out3;
    logic         group_strobe;
`ifdef DEMUX_STATS_EN
    logic [7:0]   group_cnt;
`endif

    int tests_run;
    int tests_failed;

    demux_1a4 #(.WIDTH(W), .LANES(4)) dut (
        .clk_4f       (clk_4f),
        .reset_L      (reset_L),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .data_out0    (data_out0),
        .data_out1    (data_out1),
        .data_out2    (data_out2),
        .data_out3    (data_out3),
        .valid_out0   (valid_out0),
        .valid_out1   (valid_out1),
        .valid_out2   (valid_out2),
        .valid_out3   (valid_out3),
        .group_strobe (group_strobe)
`ifdef DEMUX_STATS_EN
       ,.group_cnt    (group_cnt)
`endif
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word, let one rising edge pass, return 1 time unit after it
    task automatic drive(input logic v, input logic [W-1:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic check_lanes(input string tag,
                               input logic [W-1:0] d0, input logic [W-1:0] d1,
                               input logic [W-1:0] d2, input logic [W-1:0] d3,
                               input logic [3:0] vld, input logic stb);
        check({tag, "_d0"}, 32'(data_out0), 32'(d0));
        check({tag, "_d1"}, 32'(data_out1), 32'(d1));
        check({tag, "_d2"}, 32'(data_out2), 32'(d2));
        check({tag, "_d3"}, 32'(data_out3), 32'(d3));
        check({tag, "_vld"}, 32'({valid_out3, valid_out2, valid_out1, valid_out0}), 32'(vld));
        check({tag, "_stb"}, 32'(group_strobe), 32'(stb));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_L      = 1'b0;
        valid_in     = 1'b0;
        data_in      = 8'h00;
        repeat (3) @(posedge clk_4f);
        #1;
        check_lanes("reset", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
`ifdef DEMUX_STATS_EN
        check("reset_cnt", 32'(group_cnt), 32'd0);
`endif
        @(negedge clk_4f);
        reset_L = 1'b1;

        // Idle cycles before sync must not start a group
        drive(1'b0, 8'h99);
        drive(1'b0, 8'h98);
        check_lanes("idle", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);

        // Group 1: FF,EE,DD,CC visible one cycle after CC
        drive(1'b1, 8'hFF);
        check("g1_s0_stb", 32'(group_strobe), 32'd0);
        drive(1'b1, 8'hEE);
        drive(1'b1, 8'hDD);
        check("g1_s2_stb", 32'(group_strobe), 32'd0);
        drive(1'b1, 8'hCC);
        check_lanes("g1", 8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'b1111, 1'b1);

        // Group 2 back-to-back: outputs hold for 3 cycles, update on the 4th
        drive(1'b1, 8'hBB);
        check_lanes("g1_hold", 8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'b1111, 1'b0);
        drive(1'b1, 8'hAA);
        drive(1'b1, 8'h99);
        check_lanes("g1_hold3", 8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'b1111, 1'b0);
        drive(1'b1, 8'h88);
        check_lanes("g2", 8'hBB, 8'hAA, 8'h99, 8'h88, 4'b1111, 1'b1);

        // Group 3: only slot 2 valid; invalid slots carry garbage that must read 0
        drive(1'b0, 8'h5A);
        drive(1'b0, 8'hA5);
        drive(1'b1, 8'h77);
        drive(1'b0, 8'h3C);
        check_lanes("g3", 8'h00, 8'h00, 8'h77, 8'h00, 4'b0100, 1'b1);

        // Group 4: fully invalid, still transferred with a strobe
        drive(1'b0, 8'h33);
        drive(1'b0, 8'h33);
        drive(1'b0, 8'h33);
        drive(1'b0, 8'h33);
        check_lanes("g4", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1);

        // Back in WAIT_SYNC: idle words ignored, 55 realigns to lane 0
        drive(1'b0, 8'h12);
        check("resync_idle_stb", 32'(group_strobe), 32'd0);
        drive(1'b0, 8'h13);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h44);
        drive(1'b1, 8'h22);
        check("resync_s2_stb", 32'(group_strobe), 32'd0);
        drive(1'b1, 8'h66);
        check_lanes("g5", 8'h55, 8'h44, 8'h22, 8'h66, 4'b1111, 1'b1);

        // Reset mid-group after slots 0-1: outputs clear without a clock edge
        drive(1'b1, 8'hA1);
        drive(1'b1, 8'hA2);
        valid_in = 1'b0;
        #2;
        reset_L = 1'b0;
        #1;
        check_lanes("async_rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
        @(negedge clk_4f);
        reset_L = 1'b1;

        // Next group starting with 11 lands aligned at lane 0; A1/A2 discarded
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h12);
        check_lanes("post_rst_s1", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
        drive(1'b1, 8'h13);
        drive(1'b1, 8'h14);
        check_lanes("g6", 8'h11, 8'h12, 8'h13, 8'h14, 4'b1111, 1'b1);

`ifdef DEMUX_STATS_EN
        check("cnt_after_g6", 32'(group_cnt), 32'd1);
        for (int g = 0; g < 300; g++) begin
            for (int s = 0; s < 4; s++) begin
                drive(1'b1, 8'(g + s));
            end
        end
        check("cnt_sat", 32'(group_cnt), 32'd255);
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 8'h00);
        end
        check("cnt_invalid_grp_stb", 32'(group_strobe), 32'd1);
        check("cnt_invalid_grp", 32'(group_cnt), 32'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
